// File: rtl/gb_oam_dma.sv
// Game Boy OAM DMA engine: a write to the DMA register copies OAM_BYTES bytes
// from {src,8'h00} into OAM, one byte every BYTE_CYCLES clocks.
module gb_oam_dma #(
    parameter int unsigned OAM_BYTES    = 160,
    parameter int unsigned BYTE_CYCLES  = 4,
    parameter int unsigned START_DELAY  = 4,
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_A,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_mreq_n,
    input  logic        cpu_wr_n,
    input  logic        cpu_rd_n,
    output logic        reg_sel,
    output logic [7:0]  reg_rdata,
    output logic        dma_active,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic        oam_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata
);

    localparam int unsigned PW = (BYTE_CYCLES > 1) ? $clog2(BYTE_CYCLES) : 1;
    localparam int unsigned DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [PW-1:0] PH_LAST  = PW'(BYTE_CYCLES - 1);
    localparam logic [DW-1:0] DLY_INIT = DW'(START_DELAY - 1);
    localparam logic [7:0]    IDX_LAST = 8'(OAM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        XFER
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    src_q, src_d;
    logic [7:0]    reg_q, reg_d;
    logic          wr_n_q, wr_n_d;
    logic          active_q, active_d;
    logic          mem_rd_q, mem_rd_d;
    logic [15:0]   mem_addr_q, mem_addr_d;
    logic          oam_we_q, oam_we_d;
    logic [7:0]    oam_addr_q, oam_addr_d;
    logic [7:0]    oam_wdata_q, oam_wdata_d;

    logic       trigger;
    logic [7:0] src_map;
    logic [7:0] idx_nx;

    always_comb begin
        reg_sel = !cpu_mreq_n && !cpu_rd_n && (cpu_A == DMA_REG_ADDR);
        trigger = !cpu_mreq_n && (cpu_A == DMA_REG_ADDR) && !cpu_wr_n && wr_n_q;
        src_map = (src_q >= 8'hE0) ? (src_q - 8'h20) : src_q;
        idx_nx  = idx_q + 8'd1;
    end

    // mem_rd/oam_we are registered one edge ahead of the phase they belong to:
    // mem_rd is visible while ph_q==0, oam_we follows the ph_q==PH_LAST cycle
    // in which mem_rdata is valid.
    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        ph_d        = ph_q;
        idx_d       = idx_q;
        src_d       = src_q;
        reg_d       = reg_q;
        wr_n_d      = cpu_wr_n;
        active_d    = active_q;
        mem_rd_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        oam_we_d    = 1'b0;
        oam_addr_d  = oam_addr_q;
        oam_wdata_d = oam_wdata_q;

        case (state_q)
            IDLE: ;
            DELAY: begin
                if (dcnt_q == '0) begin
                    state_d    = XFER;
                    idx_d      = '0;
                    ph_d       = '0;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = {src_map, 8'h00};
                end else begin
                    dcnt_d = dcnt_q - DW'(1);
                end
            end
            XFER: begin
                if (ph_q == PH_LAST) begin
                    oam_we_d    = 1'b1;
                    oam_addr_d  = idx_q;
                    oam_wdata_d = mem_rdata;
                    if (idx_q == IDX_LAST) begin
                        state_d  = IDLE;
                        active_d = 1'b0;
                    end else begin
                        idx_d      = idx_nx;
                        ph_d       = '0;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = {src_map, idx_nx};
                    end
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A retrigger drops any read about to issue but lets a pending OAM write retire.
        if (trigger) begin
            src_d      = cpu_dout;
            reg_d      = cpu_dout;
            state_d    = DELAY;
            dcnt_d     = DLY_INIT;
            idx_d      = '0;
            ph_d       = '0;
            active_d   = 1'b1;
            mem_rd_d   = 1'b0;
            mem_addr_d = mem_addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            dcnt_q      <= '0;
            ph_q        <= '0;
            idx_q       <= '0;
            src_q       <= '0;
            reg_q       <= 8'hFF;
            wr_n_q      <= 1'b1;
            active_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            oam_we_q    <= 1'b0;
            oam_addr_q  <= '0;
            oam_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            ph_q        <= ph_d;
            idx_q       <= idx_d;
            src_q       <= src_d;
            reg_q       <= reg_d;
            wr_n_q      <= wr_n_d;
            active_q    <= active_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            oam_we_q    <= oam_we_d;
            oam_addr_q  <= oam_addr_d;
            oam_wdata_q <= oam_wdata_d;
        end
    end

    always_comb begin
        reg_rdata  = reg_q;
        dma_active = active_q;
        mem_rd     = mem_rd_q;
        mem_addr   = mem_addr_q;
        oam_we     = oam_we_q;
        oam_addr   = oam_addr_q;
        oam_wdata  = oam_wdata_q;
    end

endmodule

// File: tb/tb_gb_oam_dma.sv
// Bench for gb_oam_dma: a per-cycle schedule model of transfers plus a source
// memory that answers reads exactly three cycles after each mem_rd.
module tb_gb_oam_dma;

    localparam int MAXC = 8000;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_A;
    logic [7:0]  cpu_dout;
    logic        cpu_mreq_n, cpu_wr_n, cpu_rd_n;
    logic        reg_sel;
    logic [7:0]  reg_rdata;
    logic        dma_active;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        oam_we;
    logic [7:0]  oam_addr, oam_wdata;

    always #5 clk = ~clk;

    gb_oam_dma #(
        .OAM_BYTES(160), .BYTE_CYCLES(4), .START_DELAY(4), .DMA_REG_ADDR(16'hFF46)
    ) dut (
        .clk(clk), .reset(reset), .cpu_A(cpu_A), .cpu_dout(cpu_dout),
        .cpu_mreq_n(cpu_mreq_n), .cpu_wr_n(cpu_wr_n), .cpu_rd_n(cpu_rd_n),
        .reg_sel(reg_sel), .reg_rdata(reg_rdata), .dma_active(dma_active),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .oam_we(oam_we), .oam_addr(oam_addr), .oam_wdata(oam_wdata)
    );

    int tests = 0;
    int fails = 0;
    int ecount = 0;

    function automatic logic [7:0] ram_val(input logic [15:0] a);
        logic [7:0] r;
        r = a[7:0] + (a[15:8] * 8'd37);
        return r ^ 8'h5A;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, ecount, act, exp);
        end
    endtask

    // expected per-cycle outputs; index = cycle following that clock edge
    bit          exp_rd [MAXC];
    logic [15:0] exp_rd_addr [MAXC];
    bit          exp_we [MAXC];
    logic [7:0]  exp_we_addr [MAXC];
    logic [7:0]  exp_we_data [MAXC];
    bit          exp_act [MAXC];
    bit          rst_at [MAXC];
    logic [7:0]  reg_exp = 8'hFF;
    logic        prev_wr = 1'b1;

    task automatic schedule(input int r, input logic [7:0] d);
        logic [7:0] m;
        m = (d >= 8'hE0) ? d - 8'h20 : d;
        for (int c = r; c < MAXC; c++) begin
            exp_rd[c] = 1'b0;
            exp_act[c] = 1'b0;
            if (c > r) exp_we[c] = 1'b0;
        end
        for (int i = 0; i < 160; i++) begin
            if (r + 4 + 4*i < MAXC) begin
                exp_rd[r+4+4*i]      = 1'b1;
                exp_rd_addr[r+4+4*i] = {m, 8'(i)};
            end
            if (r + 8 + 4*i < MAXC) begin
                exp_we[r+8+4*i]      = 1'b1;
                exp_we_addr[r+8+4*i] = 8'(i);
                exp_we_data[r+8+4*i] = ram_val({m, 8'(i)});
            end
        end
        for (int c = r; c < r + 644 && c < MAXC; c++) exp_act[c] = 1'b1;
        reg_exp = d;
    endtask

    always @(posedge clk) begin
        ecount = ecount + 1;
        if (reset) begin
            for (int c = ecount; c < MAXC; c++) begin
                exp_rd[c] = 1'b0; exp_we[c] = 1'b0; exp_act[c] = 1'b0;
            end
            if (ecount < MAXC) rst_at[ecount] = 1'b1;
            reg_exp = 8'hFF;
        end else if (!cpu_mreq_n && cpu_A == 16'hFF46 && !cpu_wr_n && prev_wr) begin
            schedule(ecount, cpu_dout);
        end
        prev_wr = cpu_wr_n;
    end

    // observed outputs, read back by the stimulus for transaction-level checks
    bit          obs_rd [MAXC];
    logic [15:0] obs_rd_addr [MAXC];
    bit          obs_we [MAXC];
    logic [7:0]  obs_we_addr [MAXC];
    logic [7:0]  obs_we_data [MAXC];
    bit          obs_act [MAXC];
    bit          pend_v [MAXC+4];
    logic [15:0] pend_a [MAXC+4];
    logic [15:0] maddr_exp = 16'h0000;

    always @(negedge clk) begin
        int c;
        c = ecount;
        if (c >= 1 && c < MAXC) begin
            if (rst_at[c]) maddr_exp = 16'h0000;
            if (exp_rd[c]) maddr_exp = exp_rd_addr[c];
            chk("dma_active", {15'd0, dma_active}, {15'd0, exp_act[c]});
            chk("mem_rd", {15'd0, mem_rd}, {15'd0, exp_rd[c]});
            chk("mem_addr", mem_addr, maddr_exp);
            chk("oam_we", {15'd0, oam_we}, {15'd0, exp_we[c]});
            if (exp_we[c]) begin
                chk("oam_addr", {8'd0, oam_addr}, {8'd0, exp_we_addr[c]});
                chk("oam_wdata", {8'd0, oam_wdata}, {8'd0, exp_we_data[c]});
            end
            chk("reg_rdata", {8'd0, reg_rdata}, {8'd0, reg_exp});
            chk("reg_sel", {15'd0, reg_sel},
                {15'd0, (!cpu_mreq_n && !cpu_rd_n && cpu_A == 16'hFF46)});
            obs_rd[c] = (mem_rd === 1'b1);   obs_rd_addr[c] = mem_addr;
            obs_we[c] = (oam_we === 1'b1);   obs_we_addr[c] = oam_addr;
            obs_we_data[c] = oam_wdata;      obs_act[c] = (dma_active === 1'b1);
            if (mem_rd === 1'b1) begin
                pend_v[c+3] = 1'b1;
                pend_a[c+3] = mem_addr;
            end
            mem_rdata = pend_v[c] ? ram_val(pend_a[c]) : (~ram_val(mem_addr) ^ 8'h81);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d, input int hold, output int trig);
        cpu_A = a; cpu_dout = d; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
        trig = ecount + 1;
        repeat (hold) step();
        cpu_wr_n = 1'b1; cpu_mreq_n = 1'b1;
    endtask

    task automatic wait_fall(input int budget, output int f);
        f = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (!obs_act[ecount]) begin f = ecount; break; end
        end
        if (f < 0) begin
            tests++; fails++;
            $display("FAIL wait_fall timeout cycle %0d: dma_active still 1 expected 0", ecount);
            f = ecount;
        end
    endtask

    task automatic wait_we(input logic [7:0] a, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (obs_we[ecount] && obs_we_addr[ecount] == a) begin hit = 1'b1; break; end
        end
        if (!hit) begin
            tests++; fails++;
            $display("FAIL wait_we timeout cycle %0d: oam_addr %0d never written", ecount, a);
        end
    endtask

    function automatic int count_we(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (obs_we[c]) n++;
        return n;
    endfunction

    function automatic int count_rd(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (obs_rd[c]) n++;
        return n;
    endfunction

    function automatic int count_low(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (!obs_act[c]) n++;
        return n;
    endfunction

    function automatic int first_rd(input int lo);
        for (int c = lo; c < MAXC; c++) if (obs_rd[c]) return c;
        return -1;
    endfunction

    function automatic int first_we(input int lo);
        for (int c = lo; c < MAXC; c++) if (obs_we[c]) return c;
        return -1;
    endfunction

    function automatic int last_rd(input int lo, input int hi);
        int l = -1;
        for (int c = lo; c <= hi; c++) if (obs_rd[c]) l = c;
        return l;
    endfunction

    initial begin
        int t, t1, f, base, k;
        reset = 1'b1; cpu_A = 16'h0000; cpu_dout = 8'h00;
        cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1; cpu_rd_n = 1'b1; mem_rdata = 8'h00;
        repeat (3) step();
        reset = 1'b0;

        base = ecount;
        repeat (100) step();
        chk("idle_no_rd", 16'(count_rd(base, ecount)), 16'd0);
        chk("idle_no_we", 16'(count_we(base, ecount)), 16'd0);
        chk("idle_reg", {8'd0, reg_rdata}, 16'h00FF);

        cpu_wr(16'hFF46, 8'hC1, 1, t);
        wait_fall(800, f);
        k = first_rd(t);
        chk("c1_latency", 16'(k - t), 16'd4);
        chk("c1_first_addr", obs_rd_addr[k], 16'hC100);
        chk("c1_first_data", {8'd0, obs_we_data[first_we(t)]}, 16'h00BF);
        chk("c1_we_count", 16'(count_we(t + 1, f)), 16'd160);
        chk("c1_busy", 16'(f - t), 16'd644);
        chk("c1_fall_with_last", {15'd0, obs_we[f]}, 16'd1);
        chk("c1_last_addr", {8'd0, obs_we_addr[f]}, 16'd159);
        chk("c1_reg", {8'd0, reg_rdata}, 16'h00C1);

        repeat (5) step();
        cpu_wr(16'hFF46, 8'hE3, 1, t);
        wait_fall(800, f);
        chk("e3_first_addr", obs_rd_addr[first_rd(t)], 16'hC300);
        chk("e3_last_addr", obs_rd_addr[last_rd(t, f)], 16'hC39F);
        chk("e3_first_data", {8'd0, obs_we_data[first_we(t)]}, 16'h0075);
        chk("e3_we_count", 16'(count_we(t + 1, f)), 16'd160);

        repeat (5) step();
        cpu_wr(16'hFF46, 8'h80, 1, t);
        wait_we(8'd50, 400);
        cpu_wr(16'hFF46, 8'h90, 1, t1);
        wait_fall(800, f);
        chk("rt_never_low", 16'(count_low(t, f - 1)), 16'd0);
        k = first_we(t1);
        chk("rt_first_oam", {8'd0, obs_we_addr[k]}, 16'd0);
        chk("rt_first_data", {8'd0, obs_we_data[k]}, 16'h008A);
        chk("rt_first_src", obs_rd_addr[first_rd(t1)], 16'h9000);
        chk("rt_latency", 16'(first_rd(t1) - t1), 16'd4);
        chk("rt_we_count", 16'(count_we(t1, f)), 16'd160);

        repeat (5) step();
        cpu_wr(16'hFF46, 8'hC1, 1, t);
        wait_we(8'd20, 200);
        reset = 1'b1;
        step();
        reset = 1'b0;
        base = ecount;
        repeat (100) step();
        chk("abort_no_we", 16'(count_we(base, ecount)), 16'd0);
        chk("abort_no_rd", 16'(count_rd(base, ecount)), 16'd0);
        chk("abort_active", {15'd0, dma_active}, 16'd0);
        chk("abort_reg", {8'd0, reg_rdata}, 16'h00FF);

        cpu_wr(16'hFF46, 8'hC2, 3, t);
        wait_fall(800, f);
        chk("hold_we_count", 16'(count_we(t + 1, f)), 16'd160);
        chk("hold_busy", 16'(f - t), 16'd644);
        step();
        cpu_wr(16'hFF47, 8'h12, 1, t);
        repeat (10) step();
        chk("other_addr_reg", {8'd0, reg_rdata}, 16'h00C2);
        chk("other_addr_idle", 16'(10 - count_low(t, t + 9)), 16'd0);
        cpu_A = 16'hFF46; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
        step();
        chk("read_sel", {15'd0, reg_sel}, 16'd1);
        chk("read_data", {8'd0, reg_rdata}, 16'h00C2);
        cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
        repeat (3) step();
        chk("read_no_start", {15'd0, dma_active}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
